// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } seg7_state_e;

  localparam logic [4:0] SEG7_BLANK_CODE = 5'h1F;
  localparam int         SEG7_NIBBLE_W   = 4;
  localparam logic [7:0] SEG7_OFF        = 8'hFF;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: load/value input bundle and display pin outputs of the
// scan controller. The master side drives the hex word, the slave is the
// controller itself.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8
);
  logic                                enable;
  logic                                load;
  logic [SEG7_NIBBLE_W*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]               dp_mask;
  logic [7:0]                          seg_n;
  logic [NUM_DIGITS-1:0]               an_n;
  logic                                load_ack;
  logic                                frame_done;

  modport master (
    output enable, load, value, dp_mask,
    input  seg_n, an_n, load_ack, frame_done
  );

  modport slave (
    input  enable, load, value, dp_mask,
    output seg_n, an_n, load_ack, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl_hex_code.sv
// hex_code: 5-bit code to active-low seven-segment pattern {dp, g..a}.
// Codes 0..F give the hex glyph; anything else (notably 5'h1F) is all off.
// The DP bit is always driven off here; the caller supplies its own.
module hex_code
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg_n
);

  // Glyph lookup, default branch doubles as the blanking code
  always_comb begin
    seg_n = SEG7_OFF;
    case (code)
      5'h00: seg_n = 8'hC0;
      5'h01: seg_n = 8'hF9;
      5'h02: seg_n = 8'hA4;
      5'h03: seg_n = 8'hB0;
      5'h04: seg_n = 8'h99;
      5'h05: seg_n = 8'h92;
      5'h06: seg_n = 8'h82;
      5'h07: seg_n = 8'hF8;
      5'h08: seg_n = 8'h80;
      5'h09: seg_n = 8'h90;
      5'h0A: seg_n = 8'h88;
      5'h0B: seg_n = 8'h83;
      5'h0C: seg_n = 8'hC6;
      5'h0D: seg_n = 8'hA1;
      5'h0E: seg_n = 8'h86;
      5'h0F: seg_n = 8'h8E;
      default: seg_n = SEG7_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-anode digits
// through a single shared hex_code decoder. Each digit slot is REFRESH_DIV
// cycles: BLANK_CYCLES dark, the rest lit. New words are double-buffered and
// only reach the display at a frame wrap (or immediately while idle).
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int VAL_W = SEG7_NIBBLE_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

  seg7_state_e             state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx, idx_nx;

  logic [VAL_W-1:0]        disp_reg, pend_reg;
  logic [NUM_DIGITS-1:0]   dp_disp, dp_pend;
  logic                    pend_valid;

  logic                    slot_end, frame_wrap, boundary;
  logic [NUM_DIGITS-1:0]   lz_keep;
  logic [SEG7_NIBBLE_W-1:0] nib;
  logic [4:0]              dec_code;
  logic [7:0]              dec_seg_n;
  logic                    dp_n;

  logic [7:0]              seg_n_r;
  logic [NUM_DIGITS-1:0]   an_n_r;
  logic                    load_ack_r, frame_done_r;

  assign slot_end   = (state == SHOW) && (cnt == CNT_SLOT_END);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  // Idle counts as a permanent boundary so loads there are shown at once
  assign boundary   = (state == IDLE) || frame_wrap;

  // State, slot counter and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic: the slot counter runs 0..REFRESH_DIV-1 across BLANK+SHOW
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (!bus.enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
        BLANK: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_BLANK_END) state_nx = SHOW;
        end
        SHOW: begin
          if (slot_end) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic lz_seen;

  // Keep a digit if it or any higher digit is nonzero; digit 0 always kept
  always_comb begin
    lz_seen = 1'b0;
    lz_keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_seen    = lz_seen | (SEG7_NIBBLE_W'(disp_reg >> (i * SEG7_NIBBLE_W)) != '0);
      lz_keep[i] = lz_seen | (i == 0);
    end
  end
`else
  assign lz_keep = '1;
`endif

  // Decoder input selected for the digit that will be lit after the next edge,
  // so segments and anodes are registered together and never skew
  always_comb begin
    nib      = SEG7_NIBBLE_W'(disp_reg >> (idx_nx * SEG7_NIBBLE_W));
    dec_code = SEG7_BLANK_CODE;
    dp_n     = 1'b1;
    if (state_nx == SHOW) begin
      dec_code = lz_keep[idx_nx] ? {1'b0, nib} : SEG7_BLANK_CODE;
      dp_n     = ~dp_disp[idx_nx];
    end
  end

  hex_code u_hex_code (
    .code  (dec_code),
    .seg_n (dec_seg_n)
  );

  // Double buffer: bypass or transfer at a boundary, otherwise park in pend_reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg   <= '0;
      dp_disp    <= '0;
      pend_reg   <= '0;
      dp_pend    <= '0;
      pend_valid <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        disp_reg   <= bus.value;
        dp_disp    <= bus.dp_mask;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        disp_reg   <= pend_reg;
        dp_disp    <= dp_pend;
        pend_valid <= 1'b0;
      end
    end else if (bus.load) begin
      pend_reg   <= bus.value;
      dp_pend    <= bus.dp_mask;
      pend_valid <= 1'b1;
    end
  end

  // Registered display pins and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n_r      <= SEG7_OFF;
      an_n_r       <= '1;
      load_ack_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      an_n_r       <= (state_nx == SHOW) ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
      // decoder DP is always off, so the AND only lets our own DP through
      seg_n_r      <= {dp_n & dec_seg_n[7], dec_seg_n[6:0]};
      load_ack_r   <= boundary && (bus.load || pend_valid);
      frame_done_r <= frame_wrap;
    end
  end

  assign bus.seg_n      = seg_n_r;
  assign bus.an_n       = an_n_r;
  assign bus.load_ack   = load_ack_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller that shares one `hex_code` seven-segment decoder across `NUM_DIGITS` common-anode digits on the board display. It sits between the FP MAC result/debug path and the display pins. It accepts a packed hex word with a load strobe, holds it in a tear-free double buffer, and cycles the digits with a blanking gap to prevent ghosting.

## Interface
- `NUM_DIGITS`, 8: digits scanned, legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all anodes off; must be at least 1.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; 0 forces the display dark.
- `load`  in  1  one-cycle strobe that captures `value` and `dp_mask`.
- `value`  in  4*NUM_DIGITS  hex nibbles; nibble i is shown on digit i; digit 0 is least significant and rightmost.
- `dp_mask`  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- `seg_n`  out  8  active-low segments; bit 7 = DP, bits 6..0 = g..a, taken from the decoder.
- `an_n`  out  NUM_DIGITS  active-low anode selects; at most one bit low at any time.
- `load_ack`  out  1  one-cycle pulse when a captured value becomes visible.
- `frame_done`  out  1  one-cycle pulse when digit `NUM_DIGITS-1` finishes its slot.

## Operation
- Buffers:
  - `pend_reg`/`pend_valid` are written on `load`. A later `load` before transfer overwrites `pend_reg`.
  - `disp_reg` drives the decoder.
  - Transfer `pend_reg` to `disp_reg` only at a frame boundary (digit index wraps) or while in IDLE. Pulse `load_ack` in the transfer cycle.
- Load at a boundary: if `load` arrives in the same cycle as a boundary, the incoming value bypasses straight into `disp_reg`, `pend_valid` stays 0, and `load_ack` pulses.
- FSM states:
  - IDLE: all anodes off, `seg_n`=8'hFF, index=0.
  - BLANK: anodes off, `seg_n`=8'hFF for `BLANK_CYCLES` cycles.
  - SHOW: `an_n[idx]`=0 for `REFRESH_DIV-BLANK_CYCLES` cycles. Decoder input = {1'b0, `disp_reg` nibble idx}. `seg_n[7]` = ~`dp_mask_disp[idx]`.
- Transitions:
  - IDLE to BLANK when `enable`=1.
  - BLANK to SHOW when the slot counter reaches `BLANK_CYCLES-1`.
  - SHOW to BLANK when the slot counter reaches `REFRESH_DIV-1`; the index increments, wrapping from `NUM_DIGITS-1` to 0.
  - Any state goes to IDLE on the next edge when `enable`=0. The slot counter and index clear.
- Slot counter: width clog2(`REFRESH_DIV`), clears on every slot end.
- Blank code: a 5-bit code of 5'h1F yields decoder all-off (its default branch).

## Timing
- Reset values:
  - `seg_n`=8'hFF, `an_n`=all ones, `load_ack`=0, `frame_done`=0.
  - FSM=IDLE, index=0, slot counter=0.
  - `disp_reg`=0, `pend_reg`=0, `pend_valid`=0.
- Outputs are registered. `seg_n` and `an_n` change on the same edge as the state, so segments never change while an anode is active.
- Digit period = `REFRESH_DIV` cycles. Frame = `NUM_DIGITS*REFRESH_DIV` cycles.
- `frame_done` is asserted in the cycle SHOW leaves the last digit.
- Load latency: a value loaded in IDLE is visible at the first SHOW. Otherwise it becomes visible at the next frame boundary, at most one frame later.
- Reset mid-slot: outputs go dark immediately (asynchronous), with no partial frame afterwards.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Any digit above the most significant nonzero nibble of `disp_reg` gets code 5'h1F.
  - Digit 0 is always shown.
  - The DP on a blanked digit still follows `dp_mask`.
  - The blanking mask is computed from `disp_reg`, so it also changes only at frame boundaries.
- Not defined: all digits show their nibble, including leading zeros.

## Structure
- Package `seg7_pkg`: FSM state enum (IDLE, BLANK, SHOW), `SEG7_BLANK_CODE`=5'h1F, `SEG7_NIBBLE_W`=4, `SEG7_OFF`=8'hFF.
- Sub-module: exactly one `hex_code` instance, shared by all digits. Its 8-bit output bits 6..0 feed `seg_n[6:0]`; bit 7 is replaced by the DP logic.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset, then `enable`=1, load `value`=16'h12AF, `dp_mask`=4'b0100 in IDLE. Required response:
  - `load_ack` pulses.
  - Digit 0 shows `seg_n`=8'h8E (F) with `an_n`=4'b1110 for 6 cycles after 2 dark cycles.
  - Digit 2 shows 8'h24 (2 with DP lit).
  - `frame_done` pulses every 32 cycles.
- Load 16'h0000 mid-frame. Required response: the old value persists until the wrap; `load_ack` pulses in the same cycle as `frame_done`.
- Two loads (16'h1111, then 16'h2222) within one frame. Required response: only 16'h2222 is ever displayed; exactly one `load_ack`.
- Drop `enable` during a SHOW on digit 1. Required response: next edge gives `an_n`=4'hF, `seg_n`=8'hFF; re-enable restarts at digit 0 after 2 dark cycles.
- With `SEG7_LZ_BLANK_EN` defined, load 16'h0050. Required response: digits 3 and 2 output 8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0. Load 16'h0000: digit 0 shows 8'hC0, the others dark.
- Assert `rst_n`=0 asynchronously mid-slot. Required response: all outputs return to reset values before the next clock edge.
